// File: rtl/alu_result_stage.sv
// Registered output stage behind the 4-bit ALU: a small FIFO of result + flags + opcode
// behind a valid/ready handshake, with sticky carry/overflow status and a saturating op counter.
module alu_result_stage #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [3:0]         in_result,
    input  logic               in_cout,
    input  logic               in_overflow,
    input  logic               in_zero,
    input  logic               in_set,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_op,
    output logic [3:0]         out_result,
    output logic [3:0]         out_flags,
    output logic               sticky_ovf,
    output logic               sticky_cout,
    input  logic               clear_sticky,
    output logic [COUNT_W-1:0] op_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 11;
    localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Carry and overflow only mean something for ADD/SUB (op[1:0] == 2'b10).
    function automatic logic [3:0] mask_flags(input logic [2:0] op, input logic cout,
                                              input logic ovf, input logic zero,
                                              input logic set);
        logic arith;
        arith = (op[1:0] == 2'b10);
        return {cout & arith, ovf & arith, zero, set};
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_op_q, out_op_d;
    logic [3:0]         out_result_q, out_result_d;
    logic [3:0]         out_flags_q, out_flags_d;
    logic               sticky_ovf_q, sticky_ovf_d;
    logic               sticky_cout_q, sticky_cout_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;

    logic               push;
    logic               pop;
    logic               arith;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign push     = in_valid & in_ready_q;
    assign pop      = out_valid_q & out_ready;
    assign arith    = (in_op[1:0] == 2'b10);
    assign in_entry = {in_op, in_result, mask_flags(in_op, in_cout, in_overflow, in_zero, in_set)};

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        in_ready_d  = (occ_d < DEPTH_OCC);
        out_valid_d = (occ_d != '0);

        // The next head is being written this very edge when the queue drains to the new entry.
        head_entry = (push && (wr_ptr_q == rd_ptr_d)) ? in_entry : mem_q[rd_ptr_d];

        out_op_d     = out_op_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (occ_d != '0) begin
            out_op_d     = head_entry[10:8];
            out_result_d = head_entry[7:4];
            out_flags_d  = head_entry[3:0];
        end

        // A setting event in the same cycle as a clear wins.
        sticky_ovf_d  = (sticky_ovf_q  & ~clear_sticky) | (push & arith & in_overflow);
        sticky_cout_d = (sticky_cout_q & ~clear_sticky) | (push & arith & in_cout);

        op_count_d = push ? sat_inc(op_count_q) : op_count_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_result_q  <= '0;
            out_flags_q   <= '0;
            sticky_ovf_q  <= 1'b0;
            sticky_cout_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_result_q  <= out_result_d;
            out_flags_q   <= out_flags_d;
            sticky_ovf_q  <= sticky_ovf_d;
            sticky_cout_q <= sticky_cout_d;
            op_count_q    <= op_count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_result  = out_result_q;
    assign out_flags   = out_flags_q;
    assign sticky_ovf  = sticky_ovf_q;
    assign sticky_cout = sticky_cout_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (DEPTH=2, COUNT_W=3): reset, backpressure, masking,
// sticky status, streaming, counter saturation and reset with entries stored.
module tb_alu_result_stage;

    localparam int DEPTH   = 2;
    localparam int COUNT_W = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [3:0]         in_result;
    logic               in_cout;
    logic               in_overflow;
    logic               in_zero;
    logic               in_set;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_op;
    logic [3:0]         out_result;
    logic [3:0]         out_flags;
    logic               sticky_ovf;
    logic               sticky_cout;
    logic               clear_sticky;
    logic [COUNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_mis = 0;

    alu_result_stage #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_result(in_result),
        .in_cout(in_cout), .in_overflow(in_overflow), .in_zero(in_zero), .in_set(in_set),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_result(out_result), .out_flags(out_flags),
        .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout), .clear_sticky(clear_sticky),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] res,
                         input logic c, input logic o, input logic z, input logic s);
        in_valid    = v;
        in_op       = op;
        in_result   = res;
        in_cout     = c;
        in_overflow = o;
        in_zero     = z;
        in_set      = s;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        drive(1'b0, OP_AND, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_op", out_op, 0);
        check("rst_stickies", {sticky_ovf, sticky_cout}, 0);
        check("rst_op_count", op_count, 0);

        // Single ADD transfer
        drive(1'b1, OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("single_valid", out_valid, 1);
        check("single_result", out_result, 0);
        check("single_op", out_op, OP_ADD);
        check("single_flags", out_flags, 4'b1010);
        check("single_sticky_cout", sticky_cout, 1);
        check("single_sticky_ovf", sticky_ovf, 0);
        check("single_op_count", op_count, 1);
        check("single_in_ready", in_ready, 1);
        drive(1'b0, OP_AND, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("single_drained", out_valid, 0);
        out_ready = 1'b0;

        // Backpressure: fill, third push refused
        drive(1'b1, OP_OR, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_in_ready_1", in_ready, 1);
        check("bp_head_1", out_result, 1);
        drive(1'b1, OP_OR, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_in_ready_full", in_ready, 0);
        check("bp_head_stable", out_result, 1);
        check("bp_op_count_2", op_count, 3);
        drive(1'b1, OP_OR, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_refused_count", op_count, 3);
        check("bp_still_full", in_ready, 0);
        check("bp_hold_head", out_result, 1);
        // Pop while full with a producer still offering: no push this cycle
        out_ready = 1'b1;
        tick();
        check("bp_pop1_valid", out_valid, 1);
        check("bp_pop1_head", out_result, 2);
        check("bp_pop1_in_ready", in_ready, 1);
        check("bp_pop1_no_push", op_count, 3);
        drive(1'b0, OP_AND, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_pop2_empty", out_valid, 0);

        // Masking and sticky status
        clear_sticky = 1'b1;
        tick();
        check("clr_stickies", {sticky_ovf, sticky_cout}, 0);
        clear_sticky = 1'b0;
        drive(1'b1, OP_OR, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("mask_or_result", out_result, 5);
        check("mask_or_flags", out_flags, 4'b0000);
        check("mask_or_stickies", {sticky_ovf, sticky_cout}, 0);
        drive(1'b1, OP_SUB, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("sub_result", out_result, 6);
        check("sub_op", out_op, OP_SUB);
        check("sub_flags", out_flags, 4'b0100);
        check("sub_sticky_ovf", sticky_ovf, 1);
        check("sub_sticky_cout", sticky_cout, 0);
        check("sub_op_count", op_count, 5);
        drive(1'b1, OP_SUB, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
        clear_sticky = 1'b1;
        tick();
        check("clr_vs_set_ovf", sticky_ovf, 1);
        check("clr_vs_set_result", out_result, 7);
        drive(1'b0, OP_AND, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("clr_only_ovf", sticky_ovf, 0);
        check("clr_only_empty", out_valid, 0);
        clear_sticky = 1'b0;
        drive(1'b1, OP_SLT, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("slt_flags", out_flags, 4'b0001);
        check("slt_op", out_op, OP_SLT);
        check("slt_op_count", op_count, 7);

        // Streaming at one entry per cycle
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, OP_AND, 4'(i % 16), 1'b0, 1'b0, (i % 16) == 0, 1'b0);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_result, i % 16);
            check("stream_in_ready", in_ready, 1);
        end
        check("stream_sat_count", op_count, 7);

        // Reset with two entries stored
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_rst_full", in_ready, 0);
        check("pre_rst_stickies", {sticky_ovf, sticky_cout}, 2'b11);
        rst_n = 1'b0;
        drive(1'b1, OP_ADD, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_stickies", {sticky_ovf, sticky_cout}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, OP_AND, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_rst_no_ghost", out_valid, 0);
        check("post_rst_count", op_count, 0);

        // Counter saturation from zero
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, OP_OR, 4'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check("sat_count", op_count, (k + 1 < 7) ? k + 1 : 7);
            check("sat_data", out_result, k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
